// File: rtl/fsm_pattern_serializer.sv
// Parallel-to-serial transmitter with a Moore control FSM (IDLE -> SHIFT -> GAP).
// Every output is a register, so the serial stream is glitch-free and one bit per clock.
module fsm_pattern_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_data_out,
  output logic                  o_bit_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam int unsigned GAP_W = (GAP_CYCLES > 32'd1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 32'd0) ? GAP_CYCLES - 32'd1 : 32'd0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_s;
  logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_s;
  logic [GAP_W-1:0]        gap_cnt_r, gap_cnt_s;
  logic                    data_out_r, data_out_s;
  logic                    bit_valid_r, bit_valid_s;
  logic                    ready_r, ready_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;

  // Bit that goes on the wire next, taken from the end selected by LSB_FIRST.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] word);
    if (LSB_FIRST) begin
      head_bit = word[0];
    end else begin
      head_bit = word[DATA_WIDTH-1];
    end
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] word);
    if (LSB_FIRST) begin
      advance = {1'b0, word[DATA_WIDTH-1:1]};
    end else begin
      advance = {word[DATA_WIDTH-2:0], 1'b0};
    end
  endfunction

  // Next-state and next-output logic; outputs default to the idle/quiet values.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    data_out_s  = IDLE_LEVEL;
    bit_valid_s = 1'b0;
    ready_s     = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_valid && ready_r) begin
          state_s     = ST_SHIFT;
          data_out_s  = head_bit(i_data);
          shift_s     = advance(i_data);
          bit_cnt_s   = LAST_BIT;
          bit_valid_s = 1'b1;
          busy_s      = 1'b1;
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Out-of-range counter values cannot occur normally; treat them as a fault.
        if (int'(bit_cnt_r) > int'(LAST_BIT)) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end else if (bit_cnt_r == '0) begin
          done_s = 1'b1;
          if (GAP_CYCLES == 32'd0) begin
            state_s = ST_IDLE;
            ready_s = 1'b1;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = GAP_LOAD;
            busy_s    = 1'b1;
          end
        end else begin
          data_out_s  = head_bit(shift_r);
          shift_s     = advance(shift_r);
          bit_cnt_s   = bit_cnt_r - CNT_ONE;
          bit_valid_s = 1'b1;
          busy_s      = 1'b1;
        end
      end
      ST_GAP: begin
        if ((GAP_CYCLES == 32'd0) || (int'(gap_cnt_r) > int'(GAP_LOAD)) || (gap_cnt_r == '0)) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_ONE;
          busy_s    = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any word in flight.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      gap_cnt_r   <= '0;
      data_out_r  <= IDLE_LEVEL;
      bit_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      data_out_r  <= data_out_s;
      bit_valid_r <= bit_valid_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign o_ready     = ready_r;
  assign o_data_out  = data_out_r;
  assign o_bit_valid = bit_valid_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;

endmodule

// File: tb/tb_fsm_pattern_serializer.sv
// Self-checking bench: three serializer configurations checked cycle by cycle against
// a word-timeline reference model (position within word + gap, computed arithmetically).
module tb_fsm_pattern_serializer;

  localparam int DW = 8;
  localparam int IW = $clog2(DW);
  localparam int N  = 3;

  logic          clk_s   = 1'b0;
  logic          rst_n_s = 1'b1;
  logic [DW-1:0] data_s  [N];
  logic          valid_s [N];
  logic          ready_s [N];
  logic          dout_s  [N];
  logic          bv_s    [N];
  logic          busy_s  [N];
  logic          done_s  [N];

  int            pos_r   [N];
  logic [DW-1:0] word_r  [N];
  logic [DW-1:0] rx_r    [N];
  logic          prev_bv_r [N];
  int            first_prev_r [N];
  int            first_last_r [N];
  int            cyc_r    = 0;
  int            checks_r = 0;
  int            errors_r = 0;

  always #5 clk_s = ~clk_s;

  fsm_pattern_serializer #(.DATA_WIDTH(DW), .GAP_CYCLES(1), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut0 (
    .i_clock(clk_s), .i_reset(rst_n_s), .i_data(data_s[0]), .i_valid(valid_s[0]),
    .o_ready(ready_s[0]), .o_data_out(dout_s[0]), .o_bit_valid(bv_s[0]),
    .o_busy(busy_s[0]), .o_done(done_s[0]));

  fsm_pattern_serializer #(.DATA_WIDTH(DW), .GAP_CYCLES(2), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut1 (
    .i_clock(clk_s), .i_reset(rst_n_s), .i_data(data_s[1]), .i_valid(valid_s[1]),
    .o_ready(ready_s[1]), .o_data_out(dout_s[1]), .o_bit_valid(bv_s[1]),
    .o_busy(busy_s[1]), .o_done(done_s[1]));

  fsm_pattern_serializer #(.DATA_WIDTH(DW), .GAP_CYCLES(0), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut2 (
    .i_clock(clk_s), .i_reset(rst_n_s), .i_data(data_s[2]), .i_valid(valid_s[2]),
    .o_ready(ready_s[2]), .o_data_out(dout_s[2]), .o_bit_valid(bv_s[2]),
    .o_busy(busy_s[2]), .o_done(done_s[2]));

  function automatic int gap_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic lsb_of(input int i);
    return (i == 1);
  endfunction

  function automatic logic il_of(input int i);
    return (i == 1);
  endfunction

  // Last timeline position still belonging to a word: the done cycle or the final gap cycle.
  function automatic int last_pos(input int i);
    return (gap_of(i) == 0) ? DW : DW + gap_of(i) - 1;
  endfunction

  // Expected {ready, busy, done, bit_valid, data_out} for the current cycle.
  function automatic logic [4:0] expect_vec(input int i);
    logic [IW-1:0] idx;
    logic          b;
    int            g;
    g = gap_of(i);
    if (pos_r[i] < 0) begin
      return {1'b1, 1'b0, 1'b0, 1'b0, il_of(i)};
    end else if (pos_r[i] < DW) begin
      idx = lsb_of(i) ? IW'(pos_r[i]) : IW'(DW - 1 - pos_r[i]);
      b   = word_r[i][idx];
      return {1'b0, 1'b1, 1'b0, 1'b1, b};
    end else if (pos_r[i] == DW) begin
      return {(g == 0), (g > 0), 1'b1, 1'b0, il_of(i)};
    end else begin
      return {1'b0, 1'b1, 1'b0, 1'b0, il_of(i)};
    end
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc_r, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [4:0] e;
    for (int i = 0; i < N; i++) begin
      e = expect_vec(i);
      check_eq($sformatf("ready[%0d]", i),     32'(ready_s[i]), 32'(e[4]));
      check_eq($sformatf("busy[%0d]", i),      32'(busy_s[i]),  32'(e[3]));
      check_eq($sformatf("done[%0d]", i),      32'(done_s[i]),  32'(e[2]));
      check_eq($sformatf("bit_valid[%0d]", i), 32'(bv_s[i]),    32'(e[1]));
      check_eq($sformatf("data_out[%0d]", i),  32'(dout_s[i]),  32'(e[0]));
      if (bv_s[i] === 1'b1) begin
        if (prev_bv_r[i] !== 1'b1) begin
          first_prev_r[i] = first_last_r[i];
          first_last_r[i] = cyc_r;
        end
        rx_r[i] = lsb_of(i) ? {dout_s[i], rx_r[i][DW-1:1]} : {rx_r[i][DW-2:0], dout_s[i]};
      end
      if (done_s[i] === 1'b1) begin
        check_eq($sformatf("word[%0d]", i), 32'(rx_r[i]), 32'(word_r[i]));
      end
      prev_bv_r[i] = bv_s[i];
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (!rst_n_s) begin
        pos_r[i] = -1;
      end else if (expect_vec(i) >= 5'b10000 && valid_s[i]) begin
        pos_r[i]  = 0;
        word_r[i] = data_s[i];
      end else if (pos_r[i] >= 0) begin
        pos_r[i]++;
        if (pos_r[i] > last_pos(i)) pos_r[i] = -1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_s);
    model_edge();
    cyc_r++;
    @(negedge clk_s);
    compare_all();
  endtask

  task automatic set_all(input logic [DW-1:0] d, input logic v);
    for (int i = 0; i < N; i++) begin
      data_s[i]  = d;
      valid_s[i] = v;
    end
  endtask

  task automatic send_all(input logic [DW-1:0] d);
    set_all(d, 1'b1);
    cycle();
    set_all(d, 1'b0);
    repeat (14) cycle();
  endtask

  task automatic reset_now();
    rst_n_s = 1'b0;
    #1;
    for (int i = 0; i < N; i++) pos_r[i] = -1;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pos_r[i] = -1; word_r[i] = '0; rx_r[i] = '0; prev_bv_r[i] = 1'b0;
      first_prev_r[i] = 0; first_last_r[i] = 0;
    end
    set_all(8'h00, 1'b0);
    #1;
    reset_now();
    repeat (10) cycle();
    rst_n_s = 1'b1;
    repeat (2) cycle();

    send_all(8'hA5);
    send_all(8'h01);

    // Back-to-back with valid held: first-bit spacing is DW + gap + 1.
    set_all(8'hF0, 1'b1);
    cycle();
    set_all(8'h0F, 1'b1);
    repeat (11) cycle();
    set_all(8'h0F, 1'b0);
    repeat (14) cycle();
    check_eq("spacing[0]", 32'(first_last_r[0] - first_prev_r[0]), 32'd10);
    check_eq("spacing[1]", 32'(first_last_r[1] - first_prev_r[1]), 32'd11);
    check_eq("spacing[2]", 32'(first_last_r[2] - first_prev_r[2]), 32'd9);

    // A valid pulse mid-word must be ignored.
    set_all(8'h00, 1'b1);
    cycle();
    set_all(8'h00, 1'b0);
    repeat (3) cycle();
    set_all(8'hFF, 1'b1);
    cycle();
    set_all(8'hFF, 1'b0);
    repeat (12) cycle();

    // Reset after bit 3 of a word, then a clean word after release.
    set_all(8'hC3, 1'b1);
    cycle();
    set_all(8'hC3, 1'b0);
    repeat (3) cycle();
    reset_now();
    repeat (3) cycle();
    rst_n_s = 1'b1;
    cycle();
    send_all(8'h3C);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) begin
        data_s[i]  = DW'($urandom());
        valid_s[i] = ($urandom_range(3, 0) == 32'd0);
      end
      cycle();
    end
    set_all(8'h00, 1'b0);
    repeat (15) cycle();

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
